// File: rtl/video_wb_pkg.sv
// Shared types for the video RAM Wishbone arbiter: FSM states, master indices
// and the request payload carried from each master to the RAM port.
package video_wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  localparam int unsigned M_VIN  = 0;
  localparam int unsigned M_VOUT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic             lock;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_watchdog.sv
// Stall counter for a granted strobe; o_tc flags the last cycle before abort.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic clk,
  input  logic nRST,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/video_wb_arbiter.sv
// Two-master Wishbone arbiter sharing the RAM port between video-in (m0) and
// video-out (m1): per-CYC grants, round-robin ties, urgent override, stall abort.
module video_wb_arbiter
  import video_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             m0_wb_CYC_I,
  input  logic             m0_wb_STB_I,
  input  logic             m0_wb_WE_I,
  input  logic             m0_wb_LOCK_I,
  input  logic [WB_SW-1:0] m0_wb_SEL_I,
  input  logic [WB_AW-1:0] m0_wb_ADR_I,
  input  logic [WB_DW-1:0] m0_wb_DAT_I,
  output logic             m0_wb_ACK_O,
  output logic             m0_wb_ERR_O,
  output logic [WB_DW-1:0] m0_wb_DAT_O,
  input  logic             m1_wb_CYC_I,
  input  logic             m1_wb_STB_I,
  input  logic             m1_wb_WE_I,
  input  logic             m1_wb_LOCK_I,
  input  logic [WB_SW-1:0] m1_wb_SEL_I,
  input  logic [WB_AW-1:0] m1_wb_ADR_I,
  input  logic [WB_DW-1:0] m1_wb_DAT_I,
  output logic             m1_wb_ACK_O,
  output logic             m1_wb_ERR_O,
  output logic [WB_DW-1:0] m1_wb_DAT_O,
  input  logic             urgent,
  output logic             p_wb_CYC_O,
  output logic             p_wb_STB_O,
  output logic             p_wb_WE_O,
  output logic             p_wb_LOCK_O,
  output logic [WB_SW-1:0] p_wb_SEL_O,
  output logic [WB_AW-1:0] p_wb_ADR_O,
  output logic [WB_DW-1:0] p_wb_DAT_O,
  input  logic [WB_DW-1:0] p_wb_DAT_I,
  input  logic             p_wb_ACK_I,
  output logic             err_irq,
  output logic [1:0]       grant
);

  if (TIMEOUT < 2 || (64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_bad_params
    $error("video_wb_arbiter: TIMEOUT must be >= 2 and below 2**CNT_W");
  end

  arb_state_t r_state;
  logic       r_last;
  logic       r_abort_m;

  wb_req_t w_m0;
  wb_req_t w_m1;
  wb_req_t w_own;
  logic    w_rq0;
  logic    w_rq1;
  logic    w_granted;
  logic    w_own_idx;
  logic    w_own_stb;
  logic    w_other_rq;
  logic    w_release;
  logic    w_abort;
  logic    w_abort_cyc;
  logic    w_tc;
  logic    w_wd_clr;
  logic    w_wd_inc;

  assign w_m0 = '{cyc: m0_wb_CYC_I, stb: m0_wb_STB_I, we: m0_wb_WE_I, lock: m0_wb_LOCK_I,
                  sel: m0_wb_SEL_I, adr: m0_wb_ADR_I, dat: m0_wb_DAT_I};
  assign w_m1 = '{cyc: m1_wb_CYC_I, stb: m1_wb_STB_I, we: m1_wb_WE_I, lock: m1_wb_LOCK_I,
                  sel: m1_wb_SEL_I, adr: m1_wb_ADR_I, dat: m1_wb_DAT_I};

  assign w_rq0       = m0_wb_CYC_I & m0_wb_STB_I;
  assign w_rq1       = m1_wb_CYC_I & m1_wb_STB_I;
  assign w_granted   = (r_state == GNT0) || (r_state == GNT1);
  assign w_own_idx   = (r_state == GNT1);
  assign w_own       = w_own_idx ? w_m1 : w_m0;
  assign w_other_rq  = w_own_idx ? w_rq0 : w_rq1;
  assign w_own_stb   = w_granted & w_own.cyc & w_own.stb;
  assign w_release   = w_granted & ~w_own.cyc & ~w_own.lock;
  assign w_abort_cyc = r_abort_m ? m1_wb_CYC_I : m0_wb_CYC_I;

  // An ACK landing on the terminal count beats the abort.
  assign w_abort  = w_own_stb & ~p_wb_ACK_I & w_tc;
  assign w_wd_inc = w_own_stb & ~p_wb_ACK_I;
  assign w_wd_clr = ~w_own_stb | p_wb_ACK_I | w_abort;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk   (clk),
    .nRST  (nRST),
    .i_clr (w_wd_clr),
    .i_inc (w_wd_inc),
    .o_tc  (w_tc)
  );

  // Grant FSM; r_last remembers the latest owner for tie-breaking.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_last    <= 1'(M_VOUT);
      r_abort_m <= 1'(M_VIN);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rq0 && w_rq1) begin
            if (urgent || r_last == 1'(M_VIN)) begin
              r_state <= GNT1;
              r_last  <= 1'(M_VOUT);
            end else begin
              r_state <= GNT0;
              r_last  <= 1'(M_VIN);
            end
          end else if (w_rq0) begin
            r_state <= GNT0;
            r_last  <= 1'(M_VIN);
          end else if (w_rq1) begin
            r_state <= GNT1;
            r_last  <= 1'(M_VOUT);
          end
        end
        GNT0, GNT1: begin
          if (w_abort) begin
            r_state   <= ABORT;
            r_abort_m <= w_own_idx;
          end else if (w_release) begin
            if (w_other_rq) begin
              r_state <= w_own_idx ? GNT0 : GNT1;
              r_last  <= ~w_own_idx;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        ABORT: begin
          if (!w_abort_cyc) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus routing decoded from the state register; non-owners see zeros.
  always_comb begin
    p_wb_CYC_O  = 1'b0;
    p_wb_STB_O  = 1'b0;
    p_wb_WE_O   = 1'b0;
    p_wb_LOCK_O = 1'b0;
    p_wb_SEL_O  = '0;
    p_wb_ADR_O  = '0;
    p_wb_DAT_O  = '0;
    m0_wb_ACK_O = 1'b0;
    m0_wb_ERR_O = 1'b0;
    m0_wb_DAT_O = '0;
    m1_wb_ACK_O = 1'b0;
    m1_wb_ERR_O = 1'b0;
    m1_wb_DAT_O = '0;
    err_irq     = 1'b0;
    grant       = 2'b00;
    if (w_granted) begin
      p_wb_CYC_O  = w_own.cyc;
      p_wb_STB_O  = w_own.stb;
      p_wb_WE_O   = w_own.we;
      p_wb_LOCK_O = w_own.lock;
      p_wb_SEL_O  = w_own.sel;
      p_wb_ADR_O  = w_own.adr;
      p_wb_DAT_O  = w_own.dat;
      err_irq     = w_abort;
    end
    if (r_state == GNT0) begin
      m0_wb_ACK_O = p_wb_ACK_I;
      m0_wb_ERR_O = w_abort;
      m0_wb_DAT_O = p_wb_DAT_I;
      grant       = 2'b01;
    end
    if (r_state == GNT1) begin
      m1_wb_ACK_O = p_wb_ACK_I;
      m1_wb_ERR_O = w_abort;
      m1_wb_DAT_O = p_wb_DAT_I;
      grant       = 2'b10;
    end
  end

endmodule

// File: tb/tb_video_wb_arbiter.sv
// Scoreboard bench for video_wb_arbiter: stimulus queues expected bus snapshots,
// a negedge monitor compares them whenever grant changes or an ACK/ERR appears.
module tb_video_wb_arbiter;

  logic clk;
  logic nRST;

  logic [1:0]  cyc, stb, we, lock;
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic        urgent;
  logic        p_ack;
  logic [31:0] p_dati;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_dato, m1_dato;
  logic        p_cyc, p_stb, p_we, p_lock;
  logic [3:0]  p_sel;
  logic [31:0] p_adr, p_dato;
  logic        err_irq;
  logic [1:0]  grant;

  typedef struct packed {
    logic [1:0]  grant;
    logic        p_cyc;
    logic        p_stb;
    logic        p_we;
    logic        p_lock;
    logic [3:0]  p_sel;
    logic [31:0] p_adr;
    logic [31:0] p_dat;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic        irq;
    logic [31:0] dat0;
    logic [31:0] dat1;
  } snap_t;

  typedef struct {
    string name;
    snap_t v;
  } exp_t;

  exp_t       expq[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic       force_chk = 1'b0;
  logic       final_chk = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  video_wb_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .m0_wb_CYC_I  (cyc[0]),
    .m0_wb_STB_I  (stb[0]),
    .m0_wb_WE_I   (we[0]),
    .m0_wb_LOCK_I (lock[0]),
    .m0_wb_SEL_I  (sel[0]),
    .m0_wb_ADR_I  (adr[0]),
    .m0_wb_DAT_I  (dat[0]),
    .m0_wb_ACK_O  (m0_ack),
    .m0_wb_ERR_O  (m0_err),
    .m0_wb_DAT_O  (m0_dato),
    .m1_wb_CYC_I  (cyc[1]),
    .m1_wb_STB_I  (stb[1]),
    .m1_wb_WE_I   (we[1]),
    .m1_wb_LOCK_I (lock[1]),
    .m1_wb_SEL_I  (sel[1]),
    .m1_wb_ADR_I  (adr[1]),
    .m1_wb_DAT_I  (dat[1]),
    .m1_wb_ACK_O  (m1_ack),
    .m1_wb_ERR_O  (m1_err),
    .m1_wb_DAT_O  (m1_dato),
    .urgent       (urgent),
    .p_wb_CYC_O   (p_cyc),
    .p_wb_STB_O   (p_stb),
    .p_wb_WE_O    (p_we),
    .p_wb_LOCK_O  (p_lock),
    .p_wb_SEL_O   (p_sel),
    .p_wb_ADR_O   (p_adr),
    .p_wb_DAT_O   (p_dato),
    .p_wb_DAT_I   (p_dati),
    .p_wb_ACK_I   (p_ack),
    .err_irq      (err_irq),
    .grant        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected snapshot when 'owner' holds the bus (-1: nobody), built from bench drives.
  function automatic snap_t mk(input int owner, input logic ack, input logic err);
    snap_t s;
    s = '0;
    if (owner >= 0) begin
      s.grant  = (owner == 1) ? 2'b10 : 2'b01;
      s.p_cyc  = cyc[owner];
      s.p_stb  = stb[owner];
      s.p_we   = we[owner];
      s.p_lock = lock[owner];
      s.p_sel  = sel[owner];
      s.p_adr  = adr[owner];
      s.p_dat  = dat[owner];
      s.irq    = err;
      if (owner == 0) begin
        s.ack0 = ack;
        s.err0 = err;
        s.dat0 = p_dati;
      end else begin
        s.ack1 = ack;
        s.err1 = err;
        s.dat1 = p_dati;
      end
    end
    return s;
  endfunction

  task automatic push(input string n, input snap_t v);
    exp_t e;
    e.name = n;
    e.v    = v;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic w,
                       input logic l, input logic [31:0] a, input logic [31:0] d);
    cyc[m]  = c;
    stb[m]  = s;
    we[m]   = w;
    lock[m] = l;
    sel[m]  = (m == 0) ? 4'hF : 4'h3;
    adr[m]  = a;
    dat[m]  = d;
  endtask

  task automatic clr_m(input int m);
    set_m(m, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One master alone; RAM acks in the lat-th granted cycle (lat >= 2).
  task automatic single_run(input string tag, input int m, input logic [31:0] a, input int lat);
    set_m(m, 1'b1, 1'b1, (m == 0), 1'b0, a, 32'h5A00_0000 ^ a);
    push({tag, "_grant"}, mk(m, 1'b0, 1'b0));
    tick();
    repeat (lat - 1) tick();
    p_ack  = 1'b1;
    p_dati = 32'hD000_0000 | a;
    push({tag, "_ack"}, mk(m, 1'b1, 1'b0));
    tick();
    p_ack  = 1'b0;
    p_dati = 32'h0;
    clr_m(m);
    push({tag, "_idle"}, mk(-1, 1'b0, 1'b0));
    tick();
    tick();
  endtask

  // Both masters request together from IDLE; 'first' is the expected winner.
  task automatic tie_run(input string tag, input logic urg, input int first);
    int sec;
    sec    = 1 - first;
    urgent = urg;
    set_m(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'hA5A5_0100);
    set_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0);
    push({tag, "_grant_first"}, mk(first, 1'b0, 1'b0));
    tick();
    tick();
    p_ack  = 1'b1;
    p_dati = 32'h1111_0000 | 32'(first);
    push({tag, "_ack_first"}, mk(first, 1'b1, 1'b0));
    tick();
    p_ack  = 1'b0;
    p_dati = 32'h0;
    clr_m(first);
    push({tag, "_handover"}, mk(sec, 1'b0, 1'b0));
    tick();
    tick();
    p_ack  = 1'b1;
    p_dati = 32'h2222_0000;
    push({tag, "_ack_second"}, mk(sec, 1'b1, 1'b0));
    tick();
    p_ack  = 1'b0;
    p_dati = 32'h0;
    urgent = 1'b0;
    clr_m(sec);
    push({tag, "_idle"}, mk(-1, 1'b0, 1'b0));
    tick();
    tick();
  endtask

  // Monitor: pops one expectation per observable bus event.
  always @(negedge clk) begin
    snap_t act;
    exp_t  e;
    act.grant  = grant;
    act.p_cyc  = p_cyc;
    act.p_stb  = p_stb;
    act.p_we   = p_we;
    act.p_lock = p_lock;
    act.p_sel  = p_sel;
    act.p_adr  = p_adr;
    act.p_dat  = p_dato;
    act.ack0   = m0_ack;
    act.ack1   = m1_ack;
    act.err0   = m0_err;
    act.err1   = m1_err;
    act.irq    = err_irq;
    act.dat0   = m0_dato;
    act.dat1   = m1_dato;
    if (force_chk || act.grant != prev_grant || act.ack0 || act.ack1 ||
        act.err0 || act.err1 || act.irq) begin
      n_checks++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got %h (grant %b) want no event", act, act.grant);
      end else begin
        e = expq.pop_front();
        if (act !== e.v) begin
          n_err++;
          $display("FAIL %s: got %h (grant %b) want %h (grant %b)",
                   e.name, act, act.grant, e.v, e.v.grant);
        end
      end
    end
    if (final_chk) begin
      n_checks++;
      if (expq.size() != 0) begin
        n_err++;
        $display("FAIL pending_events: got %0d left want 0 (next %s)",
                 expq.size(), expq[0].name);
      end
    end
    prev_grant = act.grant;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    nRST   = 1'b0;
    urgent = 1'b1;
    p_ack  = 1'b1;
    p_dati = 32'hFFFF_FFFF;
    set_m(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h20);
    set_m(1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h40);

    // Outputs stay zero while reset is held, even with live requests and ACK.
    force_chk = 1'b1;
    push("reset_state", mk(-1, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    force_chk = 1'b0;
    urgent    = 1'b0;
    p_ack     = 1'b0;
    p_dati    = 32'h0;
    clr_m(0);
    clr_m(1);
    nRST = 1'b1;
    tick();

    tie_run("rr1", 1'b0, 0);
    tie_run("rr2", 1'b0, 0);
    single_run("m0_ack_at_tc", 0, 32'h0000_0400, 8);
    tie_run("urg_last0", 1'b1, 1);
    single_run("m1_rd", 1, 32'h0000_1000, 3);
    tie_run("urg_last1", 1'b1, 1);
    tie_run("rr3", 1'b0, 1);

    // LOCK keeps m0 on the bus across a CYC gap while m1 waits.
    set_m(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h33);
    push("lock_grant", mk(0, 1'b0, 1'b0));
    tick();
    tick();
    p_ack = 1'b1;
    push("lock_ack1", mk(0, 1'b1, 1'b0));
    tick();
    p_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2004, 32'h0);
    tick();
    tick();
    tick();
    set_m(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0304, 32'h34);
    p_ack = 1'b1;
    push("lock_ack2", mk(0, 1'b1, 1'b0));
    tick();
    p_ack = 1'b0;
    clr_m(0);
    push("lock_handover", mk(1, 1'b0, 1'b0));
    tick();
    tick();
    p_ack  = 1'b1;
    p_dati = 32'h7777_0001;
    push("lock_m1_ack", mk(1, 1'b1, 1'b0));
    tick();
    p_ack  = 1'b0;
    p_dati = 32'h0;
    clr_m(1);
    push("lock_idle", mk(-1, 1'b0, 1'b0));
    tick();
    tick();

    // RAM never acks m1: ERR on the 8th granted STB cycle, then ABORT.
    set_m(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2100, 32'h0);
    push("to_grant", mk(1, 1'b0, 1'b0));
    tick();
    push("to_err", mk(1, 1'b0, 1'b1));
    push("to_abort", mk(-1, 1'b0, 1'b0));
    repeat (8) tick();
    set_m(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2100, 32'h0);
    set_m(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h55);
    tick();
    tick();
    clr_m(1);
    push("to_m0_after_abort", mk(0, 1'b0, 1'b0));
    tick();
    tick();
    tick();
    p_ack = 1'b1;
    push("to_m0_ack", mk(0, 1'b1, 1'b0));
    tick();
    p_ack = 1'b0;
    clr_m(0);
    push("to_idle", mk(-1, 1'b0, 1'b0));
    tick();
    tick();

    // Reset in the middle of an m0 burst drops everything before the next edge.
    set_m(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h66);
    push("rst_grant", mk(0, 1'b0, 1'b0));
    tick();
    tick();
    p_ack = 1'b1;
    push("rst_ack", mk(0, 1'b1, 1'b0));
    tick();
    adr[0] = 32'h0000_0604;
    push("rst_async_drop", mk(-1, 1'b0, 1'b0));
    #2;
    nRST = 1'b0;
    tick();
    p_ack = 1'b0;
    clr_m(0);
    tick();
    nRST = 1'b1;
    tick();
    tie_run("post_rst", 1'b0, 0);

    tick();
    final_chk = 1'b1;
    @(negedge clk);
    #1;
    final_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/video_wb_arbiter.md
# video_wb_arbiter

Two-master Wishbone arbiter that shares the single RAM master port between the video input writer (master 0) and the video output reader (master 1). It grants the bus per Wishbone cycle (CYC), alternating between the two masters on contention. An urgent input lets the output path pre-empt arbitration when its FIFO runs low. A watchdog aborts any cycle that the RAM never acknowledges.

## Interface
Parameters:
- TIMEOUT, 256: cycles a granted STB may wait for ACK before abort; must be ≥ 2.
- CNT_W, 9: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge.
- nRST  in  1  asynchronous, active-low reset.
- m0_wb_CYC_I, m0_wb_STB_I, m0_wb_WE_I, m0_wb_LOCK_I  in  1 each  master 0 (video in) cycle controls.
- m0_wb_SEL_I  in  4  master 0 byte select.
- m0_wb_ADR_I, m0_wb_DAT_I  in  32 each  master 0 address and write data.
- m0_wb_ACK_O, m0_wb_ERR_O  out  1 each  master 0 acknowledge and abort.
- m0_wb_DAT_O  out  32  master 0 read data.
- m1_wb_*  same set as m0_wb_*  master 1 (video out reader).
- urgent  in  1  video-out FIFO below its low watermark.
- p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O  out  1 each  to RAM.
- p_wb_SEL_O  out  4  to RAM.
- p_wb_ADR_O, p_wb_DAT_O  out  32 each  to RAM.
- p_wb_DAT_I  in  32  read data from RAM.
- p_wb_ACK_I  in  1  acknowledge from RAM.
- err_irq  out  1  one-cycle pulse on each watchdog abort.
- grant  out  2  one-hot current owner; 00 when idle.

## Operation
States: IDLE, GNT0, GNT1, ABORT. A request from master i is `mi_wb_CYC_I & mi_wb_STB_I`.

- Reset state: IDLE, last_owner=1, watchdog counter=0.
- IDLE:
  - Only one master requesting: go to that master's GNT state.
  - Both requesting with urgent=1: go to GNT1.
  - Both requesting with urgent=0: grant the master that is not last_owner.
  - On entering GNTi, set last_owner=i.
- GNTi, release:
  - Releases when `mi_wb_CYC_I=0` and `mi_wb_LOCK_I=0`.
  - On release, re-arbitrate on the same cycle's requests, excluding master i. Go to GNTj if master j is requesting, else IDLE.
  - While CYC=0 but LOCK=1, stay in GNTi.
- GNTi, watchdog:
  - Counter clears on ACK, on state change, or when STB is low.
  - Counter increments while STB=1 and ACK=0.
  - When counter = TIMEOUT-1 and ACK=0: pulse `mi_wb_ERR_O` and err_irq for that cycle, then go to ABORT.
- ABORT:
  - All p_wb control outputs are 0.
  - Stays until the aborted master drops CYC, then goes to IDLE.
  - The other master's request waits.
- Routing in GNTi (combinational from the state register):
  - `p_wb_* = mi_wb_*_I`.
  - `mi_wb_ACK_O = p_wb_ACK_I`.
  - `mi_wb_DAT_O = p_wb_DAT_I`.
  - The non-owner sees ACK=0, ERR=0, DAT_O=0.
- IDLE and ABORT:
  - p_wb CYC/STB/WE/LOCK = 0.
  - ADR, DAT, SEL = 0.
  - Both masters see ACK=0.

## Timing
- Reset values: every output is 0, including grant=00 and err_irq=0.
- Arbitration latency:
  - A request sampled in IDLE at edge N shows grant and p_wb_CYC_O from cycle N+1.
  - The master holds STB until ACK, per Wishbone classic.
- Handover:
  - Owner drops CYC in cycle K; the other master owns the bus from K+1.
  - No idle cycle between owners.
- ACK path: combinational, zero added latency. An ACK arriving in the owner's CYC-drop cycle is not possible (Wishbone rule) and needs no handling.
- Simultaneous events:
  - ACK in the same cycle the counter reaches TIMEOUT-1: ACK wins, no abort.
  - urgent changes mid-grant: no effect until the next arbitration.
- Reset asserted mid-cycle: all outputs drop asynchronously; the FSM returns to IDLE with last_owner=1.

## Structure
- Package video_wb_pkg holds:
  - the `arb_state_t` enum (IDLE, GNT0, GNT1, ABORT);
  - master index constants M_VIN=0 and M_VOUT=1.
- Watchdog is a sub-module, wb_watchdog: CNT_W-bit counter with clr, inc and a terminal-count output.
- Arbiter FSM and output muxes live in video_wb_arbiter.

## Test plan
- Single master: m1 reads at ADR 0x1000, RAM acks after 3 cycles. Expect grant=10 one cycle after request, p_wb_ADR_O=0x1000, m1_wb_ACK_O on the same cycle as p_wb_ACK_I, m0 ACK stays 0.
- Contention round-robin: both request from IDLE right after reset. Expect m0 granted first. When m0 drops CYC, m1 owns the bus next cycle, then m0 on the following tie.
- Urgent: both request, urgent=1, last_owner=0. Expect GNT1; m0 waits until m1 releases.
- Lock: m0 holds LOCK=1 across a CYC gap while m1 requests. Expect grant stays 01 until m0 clears both LOCK and CYC.
- Timeout with TIMEOUT=8: RAM never acks m1. Expect m1_wb_ERR_O and err_irq high exactly one cycle, on the 8th cycle of STB. Then p_wb_CYC_O=0, and IDLE once m1 drops CYC.
- Reset mid-transfer: assert nRST low during a GNT0 burst. Expect all outputs 0 immediately; after release, a tie grants m0 first.
